ems_page_mapper: RTL



---
 rtl/ems_page_mapper.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ems_page_mapper.sv
// LIM-style EMS page mapper for the XT bus: four 16 KB page registers and a frame
// control register behind an 8-port I/O window, plus frame slot decode for the RAM block.
module ems_page_mapper #(
   parameter logic [9:0] IO_BASE     = 10'h260,
   parameter logic [1:0] RESET_FRAME = 2'b01
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [19:0] address,
   input  logic [7:0]  internal_data_bus,
   input  logic        io_read_n,
   input  logic        io_write_n,
   output logic [7:0]  data_bus_out,
   output logic        ems_io_select_n,
   output logic [6:0]  map_ems [0:3],
   output logic        ems_b1,
   output logic        ems_b2,
   output logic        ems_b3,
   output logic        ems_b4
);

   localparam logic [2:0] OFF_INDEX = 3'd4;
   localparam logic [2:0] OFF_DATA  = 3'd5;
   localparam logic [2:0] OFF_CTRL  = 3'd6;

   logic [7:0] page_r [0:3];
   logic [1:0] index_r;
   logic       ctrl_en_r;
   logic [1:0] frame_r;
   logic       wr_prev_r;
   logic       rd_prev_r;
   logic       rd_pending_r;

   logic       io_hit_s;
   logic [2:0] offset_s;
   logic       commit_s;
   logic       rd_active_s;
   logic       rd_fall_s;
   logic       rd_rise_s;
   logic [7:0] read_mux_s;
   logic [1:0] slot_s;
   logic       hit_frame_s;
   logic [3:0] ems_hits_s;
   logic       unused_addr_s;

   // Only the frame-select nibble and slot bits matter for memory decode.
   assign unused_addr_s = ^address[13:10];

   assign io_hit_s        = (address[9:3] == IO_BASE[9:3]);
   assign offset_s        = address[2:0];
   assign ems_io_select_n = ~(io_hit_s && (!io_read_n || !io_write_n));

   // One commit per write strobe: falling edge seen against the previous sample.
   assign commit_s    = !io_write_n && wr_prev_r && io_hit_s;
   // A concurrent write strobe suppresses the whole read side.
   assign rd_active_s = !io_read_n && io_write_n && io_hit_s;
   assign rd_fall_s   = !io_read_n && rd_prev_r;
   assign rd_rise_s   = io_read_n && !rd_prev_r;

   // Strobe history for edge detection; clearing to 0 blocks a commit from a pre-held strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_prev_r <= 1'b0;
         rd_prev_r <= 1'b0;
      end else begin
         wr_prev_r <= io_write_n;
         rd_prev_r <= io_read_n;
      end
   end

   // Page register file, written directly or through DATA at the current index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            page_r[i] <= 8'h00;
         end
      end else if (commit_s) begin
         case (offset_s)
            3'd0, 3'd1, 3'd2, 3'd3: page_r[offset_s[1:0]] <= internal_data_bus;
            OFF_DATA:               page_r[index_r]       <= internal_data_bus;
            default:                ;
         endcase
      end
   end

   // Frame enable and frame select.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ctrl_en_r <= 1'b0;
         frame_r   <= RESET_FRAME;
      end else if (commit_s && (offset_s == OFF_CTRL)) begin
         ctrl_en_r <= internal_data_bus[7];
         frame_r   <= internal_data_bus[1:0];
      end
   end

   // INDEX with auto-increment on DATA writes and on completion of a DATA read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         index_r      <= 2'd0;
         rd_pending_r <= 1'b0;
      end else begin
         if (commit_s && (offset_s == OFF_INDEX)) begin
            index_r <= internal_data_bus[1:0];
         end else if (commit_s && (offset_s == OFF_DATA)) begin
            index_r <= index_r + 2'd1;
         end else if (rd_rise_s && rd_pending_r) begin
            index_r <= index_r + 2'd1;
         end

         if (rd_rise_s) begin
            rd_pending_r <= 1'b0;
         end else if (rd_fall_s && io_write_n && io_hit_s && (offset_s == OFF_DATA)) begin
            rd_pending_r <= 1'b1;
         end
      end
   end

   // Read-back multiplexer for the addressed port.
   always_comb begin
      read_mux_s = 8'hFF;
      case (offset_s)
         3'd0, 3'd1, 3'd2, 3'd3: read_mux_s = page_r[offset_s[1:0]];
         OFF_INDEX:              read_mux_s = {6'b000000, index_r};
         OFF_DATA:               read_mux_s = page_r[index_r];
         OFF_CTRL:               read_mux_s = {ctrl_en_r, 5'b00000, frame_r};
         default:                read_mux_s = 8'hFF;
      endcase
   end

   // Read data register, refreshed every clock of an active read and held otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_bus_out <= 8'h00;
      end else if (rd_active_s) begin
         data_bus_out <= read_mux_s;
      end
   end

   assign slot_s      = address[15:14];
   assign hit_frame_s = ctrl_en_r && (frame_r != 2'b11) &&
                        (address[19:16] == (4'hC + {2'b00, frame_r}));

   // One-hot slot hit; an invalid page leaves the access to conventional RAM.
   always_comb begin
      ems_hits_s = 4'b0000;
      if (hit_frame_s && page_r[slot_s][7]) begin
         ems_hits_s[slot_s] = 1'b1;
      end else begin
         ems_hits_s = 4'b0000;
      end
   end

   assign ems_b1 = ems_hits_s[0];
   assign ems_b2 = ems_hits_s[1];
   assign ems_b3 = ems_hits_s[2];
   assign ems_b4 = ems_hits_s[3];

   assign map_ems[0] = page_r[0][6:0];
   assign map_ems[1] = page_r[1][6:0];
   assign map_ems[2] = page_r[2][6:0];
   assign map_ems[3] = page_r[3][6:0];

endmodule
